// File: rtl/imm_ext_pipe.sv
// Immediate-extension stage: extends an immediate by opcode at acceptance and
// buffers {data, tag, err} in a 2-entry in-order queue with registered outputs.
module imm_ext_pipe #(
  parameter int IMM_W   = 16,
  parameter int DATA_W  = 32,
  parameter int SHIFT_B = 2,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [3:0]        in_eop,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  localparam int UP_SH = DATA_W - IMM_W;

  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_head_data;
  logic [TAG_W-1:0]  r_head_tag;
  logic              r_head_err;
  logic [DATA_W-1:0] r_tail_data;
  logic [TAG_W-1:0]  r_tail_tag;
  logic              r_tail_err;

  logic              w_accept;
  logic              w_pop;
  logic [DATA_W-1:0] w_res;
  logic              w_err;

  function automatic logic [DATA_W-1:0] f_sext(input logic [IMM_W-1:0] imm);
    return DATA_W'($signed(imm));
  endfunction

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign out_data  = r_head_data;
  assign out_tag   = r_head_tag;
  assign out_err   = r_head_err;

  always_comb begin
    w_res = {DATA_W{1'b0}};
    w_err = 1'b0;
    case (in_eop)
      4'd0:    w_res = f_sext(in_imm);
      4'd1:    w_res = DATA_W'(in_imm);
      4'd2:    w_res = DATA_W'(in_imm) << UP_SH;
      4'd3:    w_res = f_sext(in_imm) << SHIFT_B;
      default: begin
        w_res = {DATA_W{1'b0}};
        w_err = 1'b1;
      end
    endcase
  end

  // Head register is the output; the tail only holds the second entry when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= 2'd0;
      r_head_data <= {DATA_W{1'b0}};
      r_head_tag  <= {TAG_W{1'b0}};
      r_head_err  <= 1'b0;
      r_tail_data <= {DATA_W{1'b0}};
      r_tail_tag  <= {TAG_W{1'b0}};
      r_tail_err  <= 1'b0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_accept) begin
            r_head_data <= w_res;
            r_head_tag  <= in_tag;
            r_head_err  <= w_err;
            r_count     <= 2'd1;
          end
        end
        2'd1: begin
          if (w_accept && w_pop) begin
            r_head_data <= w_res;
            r_head_tag  <= in_tag;
            r_head_err  <= w_err;
          end else if (w_accept) begin
            r_tail_data <= w_res;
            r_tail_tag  <= in_tag;
            r_tail_err  <= w_err;
            r_count     <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_head_data <= r_tail_data;
            r_head_tag  <= r_tail_tag;
            r_head_err  <= r_tail_err;
            r_count     <= 2'd1;
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate-extension stage for the datapath. Accepts an immediate plus an extension opcode over a valid/ready handshake and computes a DATA_W-bit sign, zero, upper-load or branch-offset result. The result is buffered in a 2-entry in-order queue, so decode can be back-pressured by a stalled consumer without losing data. It sits between instruction decode and the ALU/branch-target operand mux, and supports a synchronous pipeline flush.

## Interface
- IMM_W, 16, immediate width in bits
- DATA_W, 32, result width; DATA_W >= IMM_W + SHIFT_B required
- SHIFT_B, 2, left shift applied in branch mode
- TAG_W, 5, width of the side-band tag carried with each entry

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards all queued entries
- in_valid  in  1  producer offers an entry
- in_ready  out  1  stage can accept; equals (count != 2)
- in_imm  in  IMM_W  immediate
- in_eop  in  4  extension opcode
- in_tag  in  TAG_W  side-band tag, passed through unchanged
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head entry
- out_data  out  DATA_W  extended result of head entry
- out_tag  out  TAG_W  tag of head entry
- out_err  out  1  head entry had an illegal opcode

## Operation
- Extension modes, computed combinationally at acceptance and stored as a result, not re-evaluated later:
  - 0 sign: replicate in_imm[IMM_W-1] into the upper DATA_W-IMM_W bits.
  - 1 zero: upper bits are 0.
  - 2 upper: in_imm << (DATA_W-IMM_W); lower bits are 0.
  - 3 branch: sign-extend, then << SHIFT_B; bits shifted out are discarded.
  - 4–15 illegal: data = 0 and err = 1.
- Queue: 2 entries, each {data, tag, err}. count is in {0,1,2}. Strict FIFO order; out_* always present the oldest entry.
- accept = in_valid & in_ready. pop = out_valid & out_ready.
- Next count, when flush = 0: count + accept − pop.
  - Accept and pop in the same cycle with count = 1: the new entry becomes head at the next edge; count stays 1.
  - Accept and pop in the same cycle with count = 0 is impossible, since out_valid = 0.
- Full (count = 2): in_ready = 0. A pop in that cycle frees a slot for the next cycle only; there is no same-cycle pass-through.
- Empty (count = 0): out_valid = 0. out_data, out_tag and out_err hold their last value and are don't-care.
- Flush: count → 0 at the next edge. Flush overrides any simultaneous accept; the offered entry is dropped. Flush overrides pop, and no pop is reported. in_ready is unaffected by flush.
- Inputs are ignored when in_valid = 0. out_ready is ignored when out_valid = 0.
- Reset may be asserted at any time, including mid-stream. All state clears immediately and the queue is empty after release.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - count = 0, so out_valid = 0 and in_ready = 1
  - out_data = 0, out_tag = 0, out_err = 0
  - all storage = 0
- Latency: an entry accepted at edge N drives out_valid = 1 with its result after edge N when the queue was empty, i.e. one cycle.
- Throughput: one entry per cycle sustained while out_ready = 1.
- in_ready and out_valid are decoded only from registered count. They have no combinational dependence on in_valid, out_ready or flush.
- out_data, out_tag and out_err are register outputs, stable for the whole cycle.
- Entry data is stable while out_valid = 1 and out_ready = 0.

## Test plan
- **Reset:** assert rst_n = 0 mid-stream with count = 2 → immediately out_valid = 0, in_ready = 1, out_data = 0. After release, the first accept appears one cycle later.
- **All modes** (defaults), in_imm = 16'h8001:
  - eop 0 → 32'hFFFF8001
  - eop 1 → 32'h00008001
  - eop 2 → 32'h80010000
  - eop 3 → 32'hFFFE0004
  - eop 7 → data 0, out_err = 1
- **Back-pressure:** out_ready = 0, offer 3 entries with tags 1, 2, 3 → tags 1 and 2 accepted, in_ready = 0 at count 2, tag 3 held by the producer. Then raise out_ready → outputs 1, 2, 3 in order, no loss and no duplicates.
- **Simultaneous accept and pop** at count = 1 for 10 cycles → count stays 1, one output per cycle, order preserved.
- **Flush:** flush with count = 2 together with a valid offer → next cycle count = 0 and out_valid = 0. The offered entry never appears at the output.
- **Parameter sweep:** IMM_W = 12, DATA_W = 64, SHIFT_B = 1, imm = 12'h800, eop 3 → 64'hFFFF_FFFF_FFFF_F000.
